addsub_serial_param: RTL and testbench
======================================

// Module: addsub_serial_param
//
// PURPOSE
//   Parametrised digit-serial adder/subtractor; next generation of the bit-serial add_serial block.
//   Latches two WIDTH-bit operands on a start request, processes DIGIT bits per cycle LSB-first,
//   and presents the result with carry/borrow and signed-overflow flags under a done/busy handshake.
//   Used wherever a small-area multi-cycle add/sub is acceptable on the datapath.
//
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal: WIDTH >= 2
//   DIGIT  1  bits processed per cycle; legal: 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0
//   (derived) NSTEPS = WIDTH/DIGIT; CW = max(1, clog2(NSTEPS))
//
// PORTS
//   clk    in   1      clock, all logic on rising edge
//   rst_n  in   1      synchronous active-low reset
//   en     in   1      start request; sampled only in IDLE and DONE
//   sub    in   1      mode, sampled with en: 0 = a+b, 1 = a-b
//   a      in   WIDTH  operand A, sampled with en
//   b      in   WIDTH  operand B, sampled with en
//   out    out  WIDTH  result, registered
//   cout   out  1      final carry; for sub: 1 = no borrow, 0 = borrow
//   ovf    out  1      two's-complement signed overflow of the operation
//   busy   out  1      high while in ADD
//   done   out  1      high while in DONE; out/cout/ovf valid and stable
//
// BEHAVIOUR
//   Reset: rst_n low at a clk edge -> state=IDLE; out, cout, ovf, internal a_reg/b_reg/carry/count = 0.
//     busy=done=0. Reset overrides everything, including mid-ADD (operation discarded, no done pulse).
//   States: IDLE, ADD, DONE (2-bit encoding). busy = (state==ADD), done = (state==DONE), both combinational from state.
//   Load (IDLE or DONE, en=1 at edge T): a_reg<=a; b_reg<= sub ? ~b : b; carry<=sub; mode_q<=sub;
//     count<=0; out<=0; cout<=0; ovf<=0; state<=ADD.
//   IDLE, en=0: hold. DONE, en=0: hold all outputs.
//   ADD, each cycle: {c,s} = a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry (DIGIT+1 bits);
//     out <= {s, out[WIDTH-1:DIGIT]} (shift right, s enters at MSB); a_reg,b_reg >>= DIGIT; carry<=c;
//     count<=count+1. en, sub, a, b ignored throughout ADD.
//   Last step (count==NSTEPS-1): also cout<=c; ovf<=(a_reg[DIGIT-1]==b_reg[DIGIT-1]) && (s[DIGIT-1]!=a_reg[DIGIT-1]);
//     state<=DONE.
//   Latency: en at edge T -> busy for edges T+1..T+NSTEPS -> done=1 from cycle after edge T+NSTEPS.
//   Result: out = (a + b) mod 2^WIDTH or (a - b) mod 2^WIDTH, using operands sampled at T.
//   Back-to-back: en=1 in DONE reloads at that edge (no IDLE cycle); done drops next cycle, out clears to 0.
//   count never wraps: exit at NSTEPS-1; NSTEPS=1 (DIGIT=WIDTH) gives a single ADD cycle.
//   No combinational path from inputs to out/cout/ovf.
//
// TESTING
//   T1 WIDTH=8,DIGIT=1: a=0x35,b=0x4A,sub=0,en 1 cycle -> busy 8 cycles, done: out=0x7F,cout=0,ovf=0.
//   T2 add edges: 0xFF+0x01 -> out=0x00,cout=1,ovf=0; 0x7F+0x01 -> out=0x80,cout=0,ovf=1.
//   T3 sub: 0x10-0x20 -> out=0xF0,cout=0,ovf=0; 0x80-0x01 -> out=0x7F,cout=1,ovf=1; 0x00-0x00 -> 0x00,cout=1.
//   T4 WIDTH=16,DIGIT=4: busy exactly 4 cycles; 1000 random a,b,sub vs reference model (out,cout,ovf).
//   T5 handshake: en held high and a/b toggled during ADD -> no effect; en in DONE with new a=0x01,b=0x02
//      -> next cycle busy=1,done=0,out=0; done 8 cycles later with out=0x03.
//   T6 rst_n low 1 cycle at mid-ADD (count=3) -> next cycle state IDLE, all outputs 0; new op then correct.

Source files
------------

// File: rtl/addsub_serial_param.sv
// Digit-serial adder/subtractor: latches two WIDTH-bit operands, processes DIGIT bits per
// cycle LSB-first, and reports the result with carry/borrow and signed overflow on done.
module addsub_serial_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NSTEPS = WIDTH / DIGIT;
  localparam int unsigned CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [DIGIT:0]   sum;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    count_d = count_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    sum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

    case (state_q)
      IDLE, DONE: begin
        if (en) begin
          // subtraction is a + ~b + 1: invert b once and seed the carry with 1
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          count_d = '0;
          out_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        // shifting through a WIDTH+DIGIT concatenation keeps DIGIT == WIDTH legal
        out_d   = WIDTH'({sum[DIGIT-1:0], out_q} >> DIGIT);
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = sum[DIGIT];
        count_d = count_q + CW'(1);
        if (count_q == CW'(NSTEPS - 1)) begin
          cout_d  = sum[DIGIT];
          ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (sum[DIGIT-1] != a_q[DIGIT-1]);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      count_q <= count_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out  = out_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_addsub_serial_param.sv
// Self-checking bench for addsub_serial_param: bit-serial 8-bit and 4-bit-digit 16-bit instances
// checked against an integer-arithmetic reference model.
module tb_addsub_serial_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en8, sub8, cout8, ovf8, busy8, done8;
  logic [7:0]  a8, b8, out8;
  logic        en16, sub16, cout16, ovf16, busy16, done16;
  logic [15:0] a16, b16, out16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addsub_serial_param #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .sub(sub8), .a(a8), .b(b8),
    .out(out8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
  );

  addsub_serial_param #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en16), .sub(sub16), .a(a16), .b(b16),
    .out(out16), .cout(cout16), .ovf(ovf16), .busy(busy16), .done(done16)
  );

  // Reference: modular result, unsigned carry/no-borrow, signed range check.
  function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                input bit sub, output longint unsigned res, output bit c,
                                output bit v);
    longint unsigned m;
    longint sa, sb, r, hi, lo;
    m  = 64'd1 << w;
    sa = (a >= m / 2) ? longint'(a) - longint'(m) : longint'(a);
    sb = (b >= m / 2) ? longint'(b) - longint'(m) : longint'(b);
    if (sub) begin
      res = (a + m - b) % m;
      c   = (a >= b);
      r   = sa - sb;
    end else begin
      res = (a + b) % m;
      c   = ((a + b) >= m);
      r   = sa + sb;
    end
    hi = longint'(m / 2) - 1;
    lo = -longint'(m / 2);
    v  = (r > hi) || (r < lo);
  endfunction

  // Called at a negedge; returns at the first negedge where busy is low.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [7:0] o, output logic c, output logic v,
                        output logic d, output int cyc);
    a8 = a; b8 = b; sub8 = s; en8 = 1'b1;
    @(negedge clk);
    en8 = 1'b0;
    cyc = 0;
    while (busy8 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    o = out8; c = cout8; v = ovf8; d = done8;
  endtask

  task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] o, output logic c, output logic v,
                         output logic d, output int cyc);
    a16 = a; b16 = b; sub16 = s; en16 = 1'b1;
    @(negedge clk);
    en16 = 1'b0;
    cyc = 0;
    while (busy16 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    o = out16; c = cout16; v = ovf16; d = done16;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out8, cout8, ovf8, busy8, done8} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_dut8: got out=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               out8, cout8, ovf8, busy8, done8);
    end
    n_cmp++;
    if ({out16, cout16, ovf16, busy16, done16} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_dut16: got out=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               out16, cout16, ovf16, busy16, done16);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [7:0] ta[6] = '{8'h35, 8'hFF, 8'h7F, 8'h10, 8'h80, 8'h00};
    logic [7:0] tb[6] = '{8'h4A, 8'h01, 8'h01, 8'h20, 8'h01, 8'h00};
    logic       ts[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] eo[6] = '{8'h7F, 8'h00, 8'h80, 8'hF0, 8'h7F, 8'h00};
    logic       ec[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       ev[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] o;
    logic       c, v, d;
    int         cyc;
    for (int i = 0; i < 6; i++) begin
      do_op8(ta[i], tb[i], ts[i], o, c, v, d, cyc);
      n_cmp++;
      if (cyc !== 8 || d !== 1'b1) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got busy_cycles=%0d done=%b, want 8 and 1", i, cyc, d);
      end
      n_cmp++;
      if ({o, c, v} !== {eo[i], ec[i], ev[i]}) begin
        n_err++;
        $display("FAIL directed_result[%0d] %h %s %h: got out=%h cout=%b ovf=%b, want out=%h cout=%b ovf=%b",
                 i, ta[i], ts[i] ? "-" : "+", tb[i], o, c, v, eo[i], ec[i], ev[i]);
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({done8, busy8, out8, cout8, ovf8} !== {1'b1, 1'b0, eo[5], ec[5], ev[5]}) begin
      n_err++;
      $display("FAIL done_hold: got done=%b busy=%b out=%h cout=%b ovf=%b, want 1 0 %h %b %b",
               done8, busy8, out8, cout8, ovf8, eo[5], ec[5], ev[5]);
    end
  endtask

  task automatic test_random8;
    logic [7:0]      a, b, o;
    logic            s, c, v, d;
    int              cyc;
    longint unsigned mr;
    bit              mc, mv;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      model(8, a, b, s, mr, mc, mv);
      do_op8(a, b, s, o, c, v, d, cyc);
      n_cmp++;
      if (cyc !== 8 || d !== 1'b1 || {o, c, v} !== {8'(mr), mc, mv}) begin
        n_err++;
        $display("FAIL random8 %h %s %h: got out=%h cout=%b ovf=%b cyc=%0d done=%b, want %h %b %b 8 1",
                 a, s ? "-" : "+", b, o, c, v, cyc, d, 8'(mr), mc, mv);
      end
    end
  endtask

  task automatic test_random16;
    logic [15:0]     a, b, o;
    logic            s, c, v, d;
    int              cyc;
    longint unsigned mr;
    bit              mc, mv;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
      if (i < 4) begin
        a = (i[0]) ? 16'hFFFF : 16'h8000;
        b = (i[1]) ? 16'h0001 : 16'h8000;
      end
      model(16, a, b, s, mr, mc, mv);
      do_op16(a, b, s, o, c, v, d, cyc);
      n_cmp++;
      if (cyc !== 4 || d !== 1'b1 || {o, c, v} !== {16'(mr), mc, mv}) begin
        n_err++;
        $display("FAIL random16 %h %s %h: got out=%h cout=%b ovf=%b cyc=%0d done=%b, want %h %b %b 4 1",
                 a, s ? "-" : "+", b, o, c, v, cyc, d, 16'(mr), mc, mv);
      end
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    a8 = 8'h35; b8 = 8'h4A; sub8 = 1'b0; en8 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      @(negedge clk);
    end
    n_cmp++;
    if (busy8 !== 1'b1) begin
      n_err++;
      $display("FAIL hs_still_busy: got busy=%b, want 1", busy8);
    end
    en8 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({done8, out8, cout8, ovf8} !== {1'b1, 8'h7F, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL hs_ignore_inputs: got done=%b out=%h cout=%b ovf=%b, want 1 7f 0 0",
               done8, out8, cout8, ovf8);
    end
    a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0; en8 = 1'b1;
    @(negedge clk);
    en8 = 1'b0;
    n_cmp++;
    if ({busy8, done8, out8} !== {1'b1, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL hs_reload: got busy=%b done=%b out=%h, want 1 0 00", busy8, done8, out8);
    end
    cyc = 0;
    while (busy8 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if (cyc !== 8 || {done8, out8, cout8, ovf8} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL hs_second_op: got cyc=%0d done=%b out=%h cout=%b ovf=%b, want 8 1 03 0 0",
               cyc, done8, out8, cout8, ovf8);
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0]      o;
    logic            c, v, d;
    int              cyc;
    longint unsigned mr;
    bit              mc, mv;
    a8 = 8'hC3; b8 = 8'h5A; sub8 = 1'b1; en8 = 1'b1;
    @(negedge clk);
    en8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if ({out8, cout8, ovf8, busy8, done8} !== 12'h0) begin
      n_err++;
      $display("FAIL mid_reset: got out=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               out8, cout8, ovf8, busy8, done8);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy8, done8, out8} !== 10'h0) begin
      n_err++;
      $display("FAIL mid_reset_idle: got busy=%b done=%b out=%h, want 0 0 00", busy8, done8, out8);
    end
    model(8, 8'h9C, 8'h27, 1'b0, mr, mc, mv);
    do_op8(8'h9C, 8'h27, 1'b0, o, c, v, d, cyc);
    n_cmp++;
    if (cyc !== 8 || d !== 1'b1 || {o, c, v} !== {8'(mr), mc, mv}) begin
      n_err++;
      $display("FAIL post_reset_op: got out=%h cout=%b ovf=%b cyc=%0d done=%b, want %h %b %b 8 1",
               o, c, v, cyc, d, 8'(mr), mc, mv);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    en16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random8();
    test_random16();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
